// File: rtl/tx.sv
// UART transmitter: start bit, WIDTH_WORD data bits LSB first, optional even parity, CANT_BIT_STOP stop bits.
// Bit timing is 16 i_rate ticks per bit. Define UART_TX_PARITY_EN to insert the parity bit.
module tx #(
    parameter int WIDTH_WORD    = 8,
    parameter int CANT_BIT_STOP = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rate,
    input  logic                  i_tx_start,
    input  logic [WIDTH_WORD-1:0] i_data_in,
    output logic                  o_bit_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int BIT_W  = $clog2(WIDTH_WORD) + 1;
    localparam int STOP_W = $clog2(CANT_BIT_STOP + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [4:0] {
        ESPERA = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        STOP   = 5'b01000,
        PARITY = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        ESPERA = 4'b0001,
        START  = 4'b0010,
        DATA   = 4'b0100,
        STOP   = 4'b1000
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [WIDTH_WORD-1:0]   buf_q, buf_d;
    logic [3:0]              tick_q, tick_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [STOP_W-1:0]       stop_cnt_q, stop_cnt_d;
    logic                    bit_q, bit_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    logic tick_end;
    assign tick_end = i_rate && (tick_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        // 4-bit counter wraps 15 -> 0 on its own at each bit end
        if (i_rate && state_q != ESPERA) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            ESPERA: begin
                busy_d = 1'b0;
                if (i_tx_start) begin
                    buf_d   = i_data_in;
                    tick_d  = 4'd0;
                    state_d = START;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^i_data_in;
`endif
                end
            end
            START: begin
                if (tick_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick_end) begin
                    buf_d     = buf_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(WIDTH_WORD - 1)) begin
                        stop_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_end) begin
                    state_d    = STOP;
                    stop_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                if (tick_end) begin
                    if (stop_cnt_q == STOP_W'(CANT_BIT_STOP - 1)) begin
                        state_d = ESPERA;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ESPERA;
                busy_d  = 1'b0;
                tick_d  = 4'd0;
            end
        endcase

        // Line value follows the state being entered, so it is registered with no input-to-output path
        case (state_d)
            START:   bit_d = 1'b0;
            DATA:    bit_d = buf_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  bit_d = par_d;
`endif
            default: bit_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ESPERA;
            buf_q      <= '0;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            bit_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_bit_tx  = bit_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule
